// File: rtl/bf_pkg.sv
// Shared encodings for the Brainf*ck pin bridge: host modes, FSM states and
// bit positions inside the bidirectional uio pin bus.
package bf_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } bf_state_e;

  localparam int UIO_STROBE    = 0;
  localparam int UIO_MODE_LSB  = 1;
  localparam int UIO_ACK       = 3;
  localparam int UIO_OUT_VALID = 4;
  localparam int UIO_IN_FULL   = 5;
  localparam int UIO_HALTED    = 6;
  localparam int UIO_ERR       = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // The reserved mode code behaves exactly like IDLE.
  function automatic logic [1:0] decode_mode(input logic [1:0] raw);
    return (raw == 2'b11) ? MODE_IDLE : raw;
  endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module bf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    head = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/bf_io_bridge.sv
// Pin-level protocol engine between the Tiny Tapeout pins and the Brainf*ck core:
// program loading, buffered ',' input, buffered '.' output with host acknowledge.
module bf_io_bridge
  import bf_pkg::*;
#(
  parameter int PROG_AW     = 8,
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         ui_in,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uo_out,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic               prog_we,
  output logic [PROG_AW-1:0] prog_addr,
  output logic [7:0]         prog_wdata,
  output logic               core_run,
  input  logic               core_halted,
  output logic               in_valid,
  output logic [7:0]         in_data,
  input  logic               in_ready,
  input  logic               out_valid,
  input  logic [7:0]         out_data,
  output logic               out_ready
);

  localparam logic [PROG_AW:0] CNT_ONE = {{PROG_AW{1'b0}}, 1'b1};

  // Synchroniser lanes: [0] strobe, [2:1] mode, [3] ack.
  logic [3:0] sync_in;
  logic [3:0] sync_q [SYNC_STAGES];
  logic       strobe_s, ack_s;
  logic [1:0] mode_s;
  logic       strobe_prev_q, strobe_prev_d;
  logic       ack_prev_q, ack_prev_d;
  logic       strobe_rise, ack_rise;
  logic       unused_uio;

  bf_state_e        state_q, state_d;
  logic [PROG_AW:0] load_cnt_q, load_cnt_d;
  logic             err_q, err_d;
  logic             prog_we_q, prog_we_d;
  logic [PROG_AW-1:0] prog_addr_q, prog_addr_d;
  logic [7:0]       prog_wdata_q, prog_wdata_d;
  logic [7:0]       uo_out_q, uo_out_d;
  logic [7:0]       uio_out_q, uio_out_d;

  logic       fifo_flush;
  logic       in_push, in_pop, in_full, in_empty;
  logic [7:0] in_head;
  logic       out_push, out_pop, out_full, out_empty;
  logic [7:0] out_head;

  assign sync_in    = {uio_in[UIO_ACK], uio_in[UIO_MODE_LSB+1],
                       uio_in[UIO_MODE_LSB], uio_in[UIO_STROBE]};
  assign unused_uio = ^uio_in[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign strobe_s    = sync_q[SYNC_STAGES-1][0];
  assign mode_s      = decode_mode(sync_q[SYNC_STAGES-1][2:1]);
  assign ack_s       = sync_q[SYNC_STAGES-1][3];
  assign strobe_rise = ena && strobe_s && !strobe_prev_q;
  assign ack_rise    = ena && ack_s && !ack_prev_q;

  bf_sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (ui_in),
    .head  (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  bf_sync_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (out_data),
    .head  (out_head),
    .full  (out_full),
    .empty (out_empty)
  );

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    err_d         = err_q;
    prog_we_d     = 1'b0;
    prog_addr_d   = prog_addr_q;
    prog_wdata_d  = prog_wdata_q;
    strobe_prev_d = ena ? strobe_s : strobe_prev_q;
    ack_prev_d    = ena ? ack_s : ack_prev_q;
    fifo_flush    = 1'b0;
    in_push       = 1'b0;
    in_pop        = ena && !in_empty && in_ready;
    out_push      = ena && out_valid && !out_full;
    out_pop       = ack_rise && !out_empty;

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (mode_s == MODE_LOAD) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            err_d      = 1'b0;
            fifo_flush = 1'b1;
          end else if (mode_s == MODE_RUN) begin
            state_d = ST_RUN;
          end
        end
        ST_LOAD: begin
          // The extra counter bit marks an exhausted program space.
          if (strobe_rise) begin
            if (load_cnt_q[PROG_AW]) begin
              err_d = 1'b1;
            end else begin
              prog_we_d    = 1'b1;
              prog_addr_d  = load_cnt_q[PROG_AW-1:0];
              prog_wdata_d = ui_in;
              load_cnt_d   = load_cnt_q + CNT_ONE;
            end
          end
          if (mode_s == MODE_RUN)       state_d = ST_RUN;
          else if (mode_s == MODE_IDLE) state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (strobe_rise) begin
            if (in_full && !in_pop) err_d   = 1'b1;
            else                    in_push = 1'b1;
          end
          if (mode_s == MODE_IDLE) state_d = ST_IDLE;
          else if (core_halted)    state_d = ST_HALT;
        end
        default: begin
          if (mode_s == MODE_IDLE) state_d = ST_IDLE;
        end
      endcase
    end

    uo_out_d  = uo_out_q;
    uio_out_d = uio_out_q;
    if (ena) begin
      uo_out_d                 = out_head;
      uio_out_d                = '0;
      uio_out_d[UIO_OUT_VALID] = !out_empty;
      uio_out_d[UIO_IN_FULL]   = in_full;
      uio_out_d[UIO_HALTED]    = (state_q == ST_HALT);
      uio_out_d[UIO_ERR]       = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      err_q         <= 1'b0;
      prog_we_q     <= 1'b0;
      prog_addr_q   <= '0;
      prog_wdata_q  <= '0;
      strobe_prev_q <= 1'b0;
      ack_prev_q    <= 1'b0;
      uo_out_q      <= '0;
      uio_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      err_q         <= err_d;
      prog_we_q     <= prog_we_d;
      prog_addr_q   <= prog_addr_d;
      prog_wdata_q  <= prog_wdata_d;
      strobe_prev_q <= strobe_prev_d;
      ack_prev_q    <= ack_prev_d;
      uo_out_q      <= uo_out_d;
      uio_out_q     <= uio_out_d;
    end
  end

  assign uo_out     = uo_out_q;
  assign uio_out    = uio_out_q;
  assign uio_oe     = UIO_OE_MASK;
  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_wdata = prog_wdata_q;
  assign core_run   = (state_q == ST_RUN);
  assign in_valid   = !in_empty;
  assign in_data    = in_head;
  assign out_ready  = !out_full;

endmodule
